// File: rtl/fp_round_unit.sv
// fp_round_unit: rounds an unrounded single-precision value (with guard/round/sticky) per RISC-V rm.
// Optional `FP_FLUSH_SUBNORMAL_EN: subnormal rounded results are flushed to signed zero.
module fp_round_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic        valid_i,
    input  logic [31:0] to_round_i,
    input  logic [2:0]  grs_i,
    input  logic [2:0]  rm_i,
    input  logic        invalid_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    output logic [31:0] result_o,
    output logic [4:0]  fflags_o,
    output logic        valid_o,
    output logic        fu_state_o
);
    localparam logic       FU_FREE = 1'b0;
    localparam logic       FU_BUSY = 1'b1;
    localparam logic [2:0] RM_RNE  = 3'b000;
    localparam logic [2:0] RM_RTZ  = 3'b001;
    localparam logic [2:0] RM_RDN  = 3'b010;
    localparam logic [2:0] RM_RUP  = 3'b011;
    localparam logic [2:0] RM_RMM  = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADJUST, S_VALID} state_e;

    state_e      r_state;
    logic [31:0] r_x;
    logic [2:0]  r_grs;
    logic [2:0]  r_rm;
    logic        r_inv;
    logic        r_ovf;
    logic        r_unf;
    logic [23:0] r_sum;
    logic [31:0] r_result;
    logic [4:0]  r_fflags;
    logic        r_valid;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic        w_inexact;
    logic        w_illegal_rm;
    logic        w_inc;
    logic        w_carry;
    logic [7:0]  w_exp_adj;
    logic [22:0] w_man_adj;
    logic [31:0] w_res;
    logic        w_nv;
    logic        w_of;
    logic        w_uf;
    logic        w_nx;

    assign w_sign       = r_x[31];
    assign w_exp        = r_x[30:23];
    assign w_inexact    = |r_grs;
    assign w_illegal_rm = (r_rm > RM_RMM);

    always_comb begin
        w_inc = 1'b0;
        case (r_rm)
            RM_RNE:  w_inc = r_grs[2] & (r_grs[1] | r_grs[0] | r_x[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = w_inexact & w_sign;
            RM_RUP:  w_inc = w_inexact & ~w_sign;
            RM_RMM:  w_inc = r_grs[2];
            default: w_inc = 1'b0;
        endcase
    end

    // A carry out of the 23-bit mantissa leaves the low bits zero, so only the exponent moves.
    assign w_carry   = r_sum[23];
    assign w_exp_adj = w_exp + {7'd0, w_carry};
    assign w_man_adj = r_sum[22:0];

    always_comb begin
        w_res = {w_sign, w_exp_adj, w_man_adj};
        w_nv  = 1'b0;
        w_of  = 1'b0;
        w_uf  = 1'b0;
        w_nx  = w_inexact | r_ovf;
        if (w_illegal_rm) begin
            w_res = 32'h7FC0_0000;
            w_nv  = 1'b1;
            w_nx  = 1'b0;
        end else if (w_exp == 8'hFF) begin
            w_res = r_x;
            w_nx  = 1'b0;
        end else if (w_exp_adj == 8'hFF) begin
            w_of = 1'b1;
            w_nx = 1'b1;
            case (r_rm)
                RM_RTZ:  w_res = {w_sign, 31'h7F7F_FFFF};
                RM_RDN:  w_res = w_sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                RM_RUP:  w_res = w_sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
                default: w_res = {w_sign, 31'h7F80_0000};
            endcase
        end else begin
            w_uf = (w_exp_adj == 8'h00) & w_inexact;
`ifdef FP_FLUSH_SUBNORMAL_EN
            if ((w_exp_adj == 8'h00) && (w_man_adj != 23'd0)) begin
                w_res = {w_sign, 31'd0};
                w_uf  = 1'b1;
                w_nx  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_x      <= 32'd0;
            r_grs    <= 3'd0;
            r_rm     <= 3'd0;
            r_inv    <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_sum    <= 24'd0;
            r_result <= 32'd0;
            r_fflags <= 5'd0;
            r_valid  <= 1'b0;
        end else if (clk_en_i) begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (valid_i) begin
                        r_x     <= to_round_i;
                        r_grs   <= grs_i;
                        r_rm    <= rm_i;
                        r_inv   <= invalid_i;
                        r_ovf   <= overflow_i;
                        r_unf   <= underflow_i;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_sum   <= {1'b0, r_x[22:0]} + {23'd0, w_inc};
                    r_state <= S_ADJUST;
                end
                S_ADJUST: begin
                    r_result <= w_res;
                    r_fflags <= {r_inv | w_nv, 1'b0, r_ovf | w_of, r_unf | w_uf, w_nx};
                    r_state  <= S_VALID;
                end
                default: begin
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign fflags_o   = r_fflags;
    assign valid_o    = r_valid & clk_en_i;
    assign fu_state_o = (r_state == S_IDLE) ? FU_FREE : FU_BUSY;
endmodule

// File: doc/fp_round_unit.md
# fp_round_unit

Floating-point rounding stage of the MicroGT-01 FPU, directly downstream of the FP add/sub unit, which supplies its result in `float_t` form. The block takes an unrounded single-precision value with guard/round/sticky bits and applies a RISC-V rounding mode. It handles mantissa-carry renormalisation and overflow saturation, and merges upstream exception flags into RISC-V `fflags`. It is a multi-cycle FSM unit that reports FREE/BUSY like the other functional units.

## Interface

Parameters: none.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clk_en_i`  in  1  clock enable; low freezes all state.
- `valid_i`  in  1  input operand valid.
- `to_round_i`  in  32 (`float_t`)  unrounded value; mantissa is truncated to 23 bits.
- `grs_i`  in  3  guard, round, sticky bits, MSB = guard.
- `rm_i`  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- `invalid_i`, `overflow_i`, `underflow_i`  in  1 each  upstream exception flags.
- `result_o`  out  32 (`float_t`)  rounded result.
- `fflags_o`  out  5  {NV, DZ, OF, UF, NX}.
- `valid_o`  out  1  result valid pulse.
- `fu_state_o`  out  `fu_state_e`  FREE when idle, else BUSY.

## Operation

- FSM states: IDLE → ROUND → ADJUST → VALID → IDLE. A transition occurs only when `clk_en_i` = 1.
- IDLE: if `valid_i` = 1, capture `to_round_i`, `grs_i`, `rm_i` and the three flags, then go to ROUND. Otherwise stay in IDLE.
- `valid_i` is ignored outside IDLE. Upstream must check `fu_state_o` first.
- ROUND:
  - inexact = g|r|s.
  - Increment decision per mode:
    - RNE: g & (r | s | lsb).
    - RTZ: 0.
    - RDN: inexact & sign.
    - RUP: inexact & ~sign.
    - RMM: g.
  - Register the 24-bit sum {0, mantissa} + inc.
- ADJUST:
  - Mantissa carry (all-ones + 1): mantissa becomes 0 and exponent +1. A subnormal that carries into exponent 1 is handled by the same path.
  - If the exponent reaches 0xFF, set OF and NX and select the output by mode:
    - RNE/RMM: ±inf.
    - RTZ: ±0x7F7FFFFF.
    - RDN: +max finite / −inf.
    - RUP: +inf / −max finite.
  - Specials: an input exponent of 0xFF (inf/NaN) passes through unchanged, with no rounding and NX = 0.
  - Illegal `rm_i` (101–111): result 0x7FC00000, NV = 1, other computed flags 0.
- Flags:
  - NV = invalid_i | illegal rm.
  - DZ = 0.
  - OF = overflow_i | rounding overflow.
  - UF = underflow_i | (result exponent 0 & inexact).
  - NX = inexact | OF.
- VALID: `valid_o` = 1 (gated by `clk_en_i`). `result_o` and `fflags_o` are stable from this cycle and hold until the next VALID.

## Timing

- Reset (`rst_i` = 1 at a clock edge) forces:
  - state IDLE;
  - `result_o` = 0x00000000, `fflags_o` = 0, `valid_o` = 0, `fu_state_o` = FREE.
- Reset has priority over `clk_en_i`.
- Reset mid-operation aborts the operation; no `valid_o` is produced for it.
- Latency: accept at edge N (IDLE, `valid_i` = 1); `valid_o` is high during the cycle after edge N+3. Stall cycles with `clk_en_i` = 0 add one cycle each.
- Throughput: one operation per 4 enabled cycles. The cycle after VALID is IDLE and can accept a new operand.
- `fu_state_o` = BUSY in ROUND, ADJUST and VALID.
- `valid_o` is never high for more than one enabled cycle per operation.

## Configuration

- `FP_FLUSH_SUBNORMAL_EN`:
  - Defined: a rounded result with exponent 0 and non-zero mantissa is replaced by a signed zero, with UF = 1 and NX = 1.
  - Undefined: subnormal results are rounded and output as-is, with UF set per the flag rule above.
- The macro has no effect on specials, overflow or latency.

## Test plan

- RNE tie handling:
  - 0x3F800000, grs 100, rm 000 → 0x3F800000, NX = 1.
  - 0x3F800001, grs 100 → 0x3F800002, NX = 1.
- Mantissa carry: 0x3FFFFFFF, grs 110, RNE → 0x40000000, fflags 00001.
- Overflow by mode, each with grs 111:
  - 0x7F7FFFFF, RNE → 0x7F800000, fflags 00101.
  - 0x7F7FFFFF, RTZ → 0x7F7FFFFF, fflags 00001.
  - 0xFF7FFFFF, RDN → 0xFF800000, fflags 00101.
- Specials and illegal rm:
  - 0x7FC00000, `invalid_i` = 1, grs 111 → 0x7FC00000, fflags 10000.
  - 0x3F800000, rm 101 → 0x7FC00000, fflags 10000.
- Subnormal:
  - 0x00000001, grs 100, RUP → 0x00000002, UF = 1, NX = 1.
  - With `FP_FLUSH_SUBNORMAL_EN` defined → 0x00000000, UF = 1, NX = 1.
- Control:
  - Hold `clk_en_i` = 0 for 3 cycles in ADJUST → `valid_o` is delayed exactly 3 cycles.
  - Assert `rst_i` in ROUND → `valid_o` never pulses, outputs go to 0, `fu_state_o` = FREE the next cycle.
  - Back-to-back `valid_i` → second operand accepted in the cycle after VALID.
